// File: rtl/shift_reg_tx.sv
// rtl/shift_reg_tx.sv - parallel-to-serial frame transmitter (start, LSB-first data, optional parity, stop)
// Optional feature macro: SHIFT_REG_TX_PARITY_EN (adds an even-parity bit before the stop bit)
module shift_reg_tx #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_val,
    output logic         in_rdy,
    input  logic [W-1:0] in_data,
    output logic         out_bit,
    output logic         out_busy,
    output logic         done
);

    localparam int CW = $clog2(W + 1);
    // Counter holds the number of data bits still to send after the one going out now.
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SHIFT_REG_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    state_t        state_q;
    logic [W-1:0]  shreg_q;
    logic [CW-1:0] cnt_q;
    logic          out_bit_q;
    logic          busy_q;
    logic          done_q;
`ifdef SHIFT_REG_TX_PARITY_EN
    logic          parity_q;
`endif
    logic          accept;

    // A new word is taken only when idle or on the stop bit, so frames chain with no gap.
    assign in_rdy   = (state_q == IDLE) || (state_q == STOP);
    assign accept   = in_val && in_rdy;
    assign out_bit  = out_bit_q;
    assign out_busy = busy_q;
    assign done     = done_q;

    // Frame sequencer: state, shift register, bit counter and registered line outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            out_bit_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SHIFT_REG_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, STOP: begin
                    if (accept) begin
                        state_q   <= START;
                        shreg_q   <= in_data;
`ifdef SHIFT_REG_TX_PARITY_EN
                        // Parity is taken from the captured word because the data bits are shifted out.
                        parity_q  <= ^in_data;
`endif
                        out_bit_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q   <= IDLE;
                        out_bit_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                START: begin
                    state_q   <= DATA;
                    out_bit_q <= shreg_q[0];
                    shreg_q   <= shreg_q >> 1;
                    cnt_q     <= CNT_LOAD;
                end
                DATA: begin
                    if (cnt_q == '0) begin
`ifdef SHIFT_REG_TX_PARITY_EN
                        state_q   <= PARITY;
                        out_bit_q <= parity_q;
`else
                        state_q   <= STOP;
                        out_bit_q <= 1'b1;
                        done_q    <= 1'b1;
`endif
                    end else begin
                        out_bit_q <= shreg_q[0];
                        shreg_q   <= shreg_q >> 1;
                        cnt_q     <= cnt_q - CW'(1);
                    end
                end
`ifdef SHIFT_REG_TX_PARITY_EN
                PARITY: begin
                    state_q   <= STOP;
                    out_bit_q <= 1'b1;
                    done_q    <= 1'b1;
                end
`endif
                default: begin
                    state_q   <= IDLE;
                    out_bit_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_tx.sv
// tb/tb_shift_reg_tx.sv - directed self-checking bench for shift_reg_tx (W = 8)
module tb_shift_reg_tx;

    localparam int W = 8;

`ifdef SHIFT_REG_TX_PARITY_EN
    localparam int FL = 11;
    localparam logic [0:15] SEQ_A5 = {11'b01010010101, 5'b0};
    localparam logic [0:15] SEQ_3C = {11'b00011110001, 5'b0};
    localparam logic [0:15] SEQ_0F = {11'b01111000001, 5'b0};
    localparam logic [0:23] SEQ_B2B = {22'b0100000001101111111101, 2'b0};
`else
    localparam int FL = 10;
    localparam logic [0:15] SEQ_A5 = {10'b0101001011, 6'b0};
    localparam logic [0:15] SEQ_3C = {10'b0001111001, 6'b0};
    localparam logic [0:15] SEQ_0F = {10'b0111100001, 6'b0};
    localparam logic [0:23] SEQ_B2B = {20'b01000000010111111111, 4'b0};
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_val;
    logic         in_rdy;
    logic [W-1:0] in_data;
    logic         out_bit;
    logic         out_busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    shift_reg_tx #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_bit  (out_bit),
        .out_busy (out_busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reset while held, asynchronous reset in mid-frame, then three idle cycles.
    task automatic test_reset();
        reset   = 1'b1;
        in_val  = 1'b0;
        in_data = '0;
        @(negedge clk);
        checks++;
        if ({out_bit, out_busy, in_rdy, done} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_hold: got %b want 1010", {out_bit, out_busy, in_rdy, done});
        end
        reset   = 1'b0;
        in_val  = 1'b1;
        in_data = 8'h55;
        @(negedge clk);
        in_val = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy: got %b want 1", out_busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out_bit, out_busy, in_rdy, done} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_async: got %b want 1010", {out_bit, out_busy, in_rdy, done});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({out_bit, out_busy, in_rdy, done} !== 4'b1010) begin
                errors++;
                $display("FAIL reset_idle%0d: got %b want 1010", i, {out_bit, out_busy, in_rdy, done});
            end
        end
    endtask

    // One frame; optionally keeps in_val high and swaps in_data after acceptance.
    task automatic test_frame(input string name, input logic [7:0] word, input logic [0:15] seq,
                              input logic hold_val, input logic [7:0] alt_data);
        in_data = word;
        in_val  = 1'b1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s_rdy_before: got %b want 1", name, in_rdy);
        end
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            if (i == 0) begin
                in_data = alt_data;
                in_val  = hold_val;
            end
            checks++;
            if (out_bit !== seq[i]) begin
                errors++;
                $display("FAIL %s_bit%0d: got %b want %b", name, i, out_bit, seq[i]);
            end
            checks++;
            if ({out_busy, done, in_rdy} !== {1'b1, i == FL - 1, i == FL - 1}) begin
                errors++;
                $display("FAIL %s_flags%0d: got %b want %b", name, i, {out_busy, done, in_rdy},
                         {1'b1, i == FL - 1, i == FL - 1});
            end
            if (i == FL - 1) in_val = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({out_bit, out_busy, in_rdy, done} !== 4'b1010) begin
            errors++;
            $display("FAIL %s_idle_after: got %b want 1010", name, {out_bit, out_busy, in_rdy, done});
        end
    endtask

    // 0x01 then 0xFF with in_val held: stop bit of the first is followed directly by the second start.
    task automatic test_back_to_back();
        in_data = 8'h01;
        in_val  = 1'b1;
        for (int i = 0; i < 2 * FL; i++) begin
            @(negedge clk);
            if (i == 0) in_data = 8'hFF;
            checks++;
            if (out_bit !== SEQ_B2B[i]) begin
                errors++;
                $display("FAIL b2b_bit%0d: got %b want %b", i, out_bit, SEQ_B2B[i]);
            end
            checks++;
            if ({out_busy, done} !== {1'b1, (i == FL - 1) || (i == 2 * FL - 1)}) begin
                errors++;
                $display("FAIL b2b_flags%0d: got %b want %b", i, {out_busy, done},
                         {1'b1, (i == FL - 1) || (i == 2 * FL - 1)});
            end
            if (i == FL) in_val = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({out_bit, out_busy, in_rdy, done} !== 4'b1010) begin
            errors++;
            $display("FAIL b2b_idle_after: got %b want 1010", {out_bit, out_busy, in_rdy, done});
        end
    endtask

    // Reset on the 4th data bit of 0xF0, then a clean 0x0F frame.
    task automatic test_reset_mid_frame();
        in_data = 8'hF0;
        in_val  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) in_val = 1'b0;
            checks++;
            if ({out_bit, out_busy} !== 2'b01) begin
                errors++;
                $display("FAIL mid_pre%0d: got %b want 01", i, {out_bit, out_busy});
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out_bit, out_busy, in_rdy, done} !== 4'b1010) begin
            errors++;
            $display("FAIL mid_reset_async: got %b want 1010", {out_bit, out_busy, in_rdy, done});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if ({out_bit, out_busy, in_rdy, done} !== 4'b1010) begin
                errors++;
                $display("FAIL mid_no_done%0d: got %b want 1010", i, {out_bit, out_busy, in_rdy, done});
            end
        end
        test_frame("w0f", 8'h0F, SEQ_0F, 1'b0, 8'h0F);
    endtask

    initial begin
        test_reset();
        test_frame("a5", 8'hA5, SEQ_A5, 1'b0, 8'hA5);
        test_back_to_back();
        test_frame("hold3c", 8'h3C, SEQ_3C, 1'b1, 8'h00);
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_reg_tx.md
SHIFT_REG_TX -- requirements
Module: shift_reg_tx

Interface
REQ-001 SHALL have parameter W, default 8, giving the payload width in bits (W >= 1).
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_val, input, 1 bit: in_data is valid.
REQ-005 SHALL have port in_rdy, output, 1 bit: block can accept a word this cycle.
REQ-006 SHALL have port in_data, input, W bits: parallel word to serialize.
REQ-007 SHALL have port out_bit, output, 1 bit: serial line, driven from a flop, idle level 1.
REQ-008 SHALL have port out_busy, output, 1 bit: high while a frame bit (start, data, parity, stop) is on out_bit.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse during the stop-bit cycle.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-011 SHALL accept a word on a rising edge where in_val && in_rdy, capturing in_data into an internal W-bit shift register.
REQ-012 SHALL assert in_rdy in IDLE and in STOP only; 0 in START, DATA, PARITY.
REQ-013 SHALL, in the cycle after acceptance, be in START and drive out_bit = 0.
REQ-014 SHALL, in DATA, drive one payload bit per cycle, LSB first, for exactly W cycles; a down-counter of width clog2(W+1) tracks remaining bits.
REQ-015 SHALL, in STOP, drive out_bit = 1 for exactly one cycle and assert done.
REQ-016 SHALL, from STOP, go to START if a word is accepted that edge (back-to-back, no idle gap), else IDLE.
REQ-017 SHALL ignore in_data changes after acceptance; the frame reflects the captured word only.
REQ-018 SHALL ignore in_val while in_rdy = 0; no word is lost or duplicated.
REQ-019 SHALL drive out_busy = 1 in START, DATA, PARITY, STOP; 0 in IDLE.
REQ-020 SHALL produce frame length W+2 cycles (W+3 with parity), from the START cycle through the STOP cycle inclusive.

Reset
REQ-021 SHALL, on reset assertion, immediately force state IDLE, out_bit = 1, out_busy = 0, done = 0, in_rdy = 1 (combinational from IDLE), shift register and counter = 0.
REQ-022 SHALL abandon any frame in progress on reset mid-frame; no stop bit or done follows.
REQ-023 SHALL accept no word on the edge where reset is asserted; acceptance resumes on the first edge after deassertion.

Configuration
REQ-024 SHALL, when macro SHIFT_REG_TX_PARITY_EN is defined, insert state PARITY between DATA and STOP, driving out_bit = XOR of the W captured bits (even parity) for one cycle.
REQ-025 SHALL, when SHIFT_REG_TX_PARITY_EN is undefined, go DATA -> STOP directly, with no parity logic synthesized.

Verification (W = 8)
REQ-026 SHALL check: reset pulse mid-operation, then idle 3 cycles -> out_bit = 1, out_busy = 0, in_rdy = 1, done = 0 throughout.
REQ-027 SHALL check: send 0xA5 -> out_bit sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); with parity enabled, 0 is inserted before the stop bit; done is high only in the stop cycle.
REQ-028 SHALL check: 0x01 then 0xFF offered back-to-back, in_val held high -> second start bit immediately follows the first stop bit; 20 busy cycles contiguous (22 with parity; parity bits 1 then 0).
REQ-029 SHALL check: 0x3C accepted, then in_data changed to 0x00 and in_val held high during DATA -> line still shows 0,0,0,1,1,1,1,0,0 then stop; no acceptance until STOP.
REQ-030 SHALL check: reset asserted on the 4th data bit of 0xF0 -> out_bit = 1 immediately, no done pulse; next word 0x0F transmits correctly.
